memory_access_unit: RTL and testbench
=====================================

Name: memory_access_unit

Overview:
- MEM-stage load/store unit of the RV32 five-stage pipeline.
- Takes the address (ALU result), store data and access controls from the EX/MEM register and drives a request/acknowledge data-memory bus.
- Returns an aligned, sign- or zero-extended load word, which the MEM/WB register samples on its data_read_i input.
- Stalls the pipeline for the duration of each bus transaction.

Parameters:
- TIMEOUT_CYCLES, 255: ACCESS-state cycles without mem_ack_i before fault; used only when the optional feature is compiled in.

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- reset_i  input  1  synchronous, active-high reset
- valid_i  input  1  EX/MEM slot holds a live instruction
- mem_read_i  input  1  instruction is a load
- mem_write_i  input  1  instruction is a store
- funct3_i  input  3  access size/sign (RV32I load/store funct3)
- alu_result_i  input  32  effective byte address
- store_data_i  input  32  rs2 value for stores
- mem_req_o  output  1  bus request, held until ack
- mem_we_o  output  1  1 = write, 0 = read
- mem_addr_o  output  32  word address, {addr[31:2],2'b00}
- mem_be_o  output  4  byte enables, bit n = byte lane n
- mem_wdata_o  output  32  lane-replicated store data
- mem_ack_i  input  1  bus completes the access this cycle
- mem_rdata_i  input  32  read word, valid with mem_ack_i
- data_read_o  output  32  extended load result for MEM/WB
- done_o  output  1  one-cycle pulse when the access completes
- stall_o  output  1  hold IF/ID/EX/EX-MEM registers
- fault_o  output  1  one-cycle pulse on a rejected or failed access

Behaviour:
- Reset: state IDLE; mem_req_o, mem_we_o, done_o, fault_o = 0; mem_addr_o, mem_be_o, mem_wdata_o, data_read_o = 0.
  - Reset mid-transaction returns to IDLE at the next edge; mem_req_o drops that edge.
  - A late mem_ack_i after reset is ignored.
- Access condition: valid_i & (mem_read_i ^ mem_write_i).
- Illegal access, checked in IDLE; raises fault_o for one cycle, issues no bus request and does not stall:
  - mem_read_i & mem_write_i both high;
  - funct3 011, 110 or 111;
  - store funct3 100 or 101;
  - halfword with addr[0] = 1;
  - word with addr[1:0] != 0.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE -> ACCESS on a legal access. Address, byte enables, write data, we, funct3 and addr[1:0] are registered on that edge. mem_req_o = 1 from the next cycle.
  - ACCESS: mem_req_o and all bus outputs held constant. On mem_ack_i: capture and extend mem_rdata_i into data_read_o (loads only), go to DONE, drop mem_req_o at the same edge.
  - DONE: done_o = 1 for one cycle, then IDLE. A new access is accepted only from IDLE, so back-to-back accesses are two cycles apart at minimum.
- stall_o is combinational:
  - 1 in IDLE when a legal access is present;
  - 1 throughout ACCESS;
  - 0 in DONE, so the pipeline advances and MEM/WB samples data_read_o on the DONE edge.
- Minimum latency: 3 cycles (IDLE, ACCESS with ack on its first cycle, DONE).
- mem_ack_i outside ACCESS is ignored.
- Store lanes:
  - SB: be = 1 << addr[1:0], wdata = {4{byte}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{half}}.
  - SW: be = 1111.
- Load extraction: select a byte or half by the registered addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through. Loads drive mem_be_o as for the equivalent store.
- data_read_o holds its value across stores, faults and idle cycles; only a completed load updates it.

Optional Feature:
- Macro MEM_ACCESS_TIMEOUT_EN.
- Defined: a counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering ACCESS and increments each ACCESS cycle without ack. When it reaches TIMEOUT_CYCLES:
  - drop mem_req_o;
  - pulse fault_o and done_o together (DONE state);
  - leave data_read_o unchanged.
- Undefined: no counter; ACCESS waits for ack indefinitely; fault_o comes only from the illegal-access checks.

Decomposition:
- Package rv32_mem_pkg: funct3 constants (LB/LH/LW/LBU/LHU/SB/SH/SW), FSM state enum, byte-enable constants.
- One sub-module, load_extend: combinational; inputs rdata, addr[1:0], funct3; output 32-bit extended word. Instantiated once.

Test Plan:
- LW at 0x100; bus acks on the second ACCESS cycle with 0xDEADBEEF -> mem_addr_o = 0x100, be = 1111, stall_o high 3 cycles, done_o pulse, data_read_o = 0xDEADBEEF.
- LB at 0x203, rdata 0x80FF1234 -> be = 1000, data_read_o = 0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x202 -> 0x000080FF.
- SH at 0x306, data 0x0000ABCD -> mem_we_o = 1, addr 0x304, be = 1100, wdata = 0xABCDABCD. data_read_o is unchanged.
- LW at 0x102 -> fault_o one-cycle pulse, mem_req_o stays 0, stall_o stays 0. The same applies with mem_read_i and mem_write_i both high.
- reset_i during ACCESS, followed by ack one cycle later -> mem_req_o = 0 and state IDLE after the reset edge, no done_o, data_read_o = 0.
- With MEM_ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES = 4, no ack -> after 4 ACCESS cycles: mem_req_o drops, fault_o and done_o pulse together, stall_o releases.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
// RV32 MEM-stage shared types: funct3 codes, FSM states, byte lanes.
// Used by memory_access_unit and load_extend.
package rv32_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } mau_state_t;

  function automatic logic [3:0] be_of(
    input logic [1:0] size,
    input logic [1:0] off
  );
    case (size)
      2'b00:   return BE_BYTE << off;
      2'b01:   return off[1] ? BE_HI : BE_LO;
      default: return BE_WORD;
    endcase
  endfunction

  function automatic logic [31:0] lanes_of(
    input logic [1:0]  size,
    input logic [31:0] d
  );
    case (size)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load data aligner: picks byte/half by offset and
// sign- or zero-extends per funct3.
module load_extend
  import rv32_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = rdata[{addr, 3'b000} +: 8];
    h    = addr[1] ? rdata[31:16] : rdata[15:0];
    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{b[7]}}, b};
      F3_LH:   data = {{16{h[15]}}, h};
      F3_LBU:  data = {24'd0, b};
      F3_LHU:  data = {16'd0, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// RV32 MEM-stage load/store unit on a req/ack bus.
// Optional access timeout: define MEM_ACCESS_TIMEOUT_EN.
module memory_access_unit
  import rv32_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] data_read_o,
  output logic        done_o,
  output logic        stall_o,
  output logic        fault_o
);

  mau_state_t  state_q, state_d;
  logic        acc, bad, legal, illegal;
  logic [31:0] addr_q, wdata_q, data_q, ext;
  logic [3:0]  be_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        we_q;
  logic        tmo_hit, tmo_q;
  logic        take;

  always_comb begin
    acc = valid_i & (mem_read_i ^ mem_write_i);
    bad = (funct3_i inside {3'b011, 3'b110, 3'b111})
        | (mem_write_i & funct3_i[2])
        | ((funct3_i[1:0] == 2'b01) & alu_result_i[0])
        | ((funct3_i[1:0] == 2'b10)
           & (|alu_result_i[1:0]));
    legal   = acc & ~bad;
    illegal = valid_i
            & ((mem_read_i & mem_write_i) | (acc & bad));
  end

  assign take = (state_q == IDLE) & legal;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;

  assign tmo_hit = (state_q == ACCESS) & ~mem_ack_i
                 & (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= tmo_hit;
      if (take)
        cnt_q <= '0;
      else if (state_q == ACCESS && !mem_ack_i)
        cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
  assign tmo_hit    = 1'b0;
  assign tmo_q      = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (legal) state_d = ACCESS;
      ACCESS:  if (mem_ack_i || tmo_hit)
                 state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_o = (state_q == ACCESS);
    done_o    = (state_q == DONE);
    stall_o   = take | (state_q == ACCESS);
    fault_o   = ((state_q == IDLE) & illegal)
              | ((state_q == DONE) & tmo_q);
  end

  load_extend u_ext (
    .rdata  (mem_rdata_i),
    .addr   (off_q),
    .funct3 (f3_q),
    .data   (ext)
  );

  // Bus fields are frozen at acceptance and held through ACCESS.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      if (take) begin
        addr_q  <= {alu_result_i[31:2], 2'b00};
        be_q    <= be_of(funct3_i[1:0],
                         alu_result_i[1:0]);
        wdata_q <= lanes_of(funct3_i[1:0],
                            store_data_i);
        we_q    <= mem_write_i;
        f3_q    <= funct3_i;
        off_q   <= alu_result_i[1:0];
      end
      if (state_q == ACCESS && mem_ack_i && !we_q)
        data_q <= ext;
    end
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;
  assign data_read_o = data_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Random and directed bench for memory_access_unit,
// checked against a byte-level reference model.
module tb_memory_access_unit;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        valid_i, mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_result_i, store_data_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i, data_read_o;
  logic        done_o, stall_o, fault_o;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] m_rd = 32'd0;

  always #5 clk_i = ~clk_i;

  memory_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .valid_i      (valid_i),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .funct3_i     (funct3_i),
    .alu_result_i (alu_result_i),
    .store_data_i (store_data_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .data_read_o  (data_read_o),
    .done_o       (done_o),
    .stall_o      (stall_o),
    .fault_o      (fault_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h exp %h", tag, got, exp);
  endtask

  function automatic bit m_legal(input bit rd, input bit wr,
                                 input int f3, input int a);
    int sz;
    sz = f3 % 4;
    if (rd == wr) return 0;
    if (f3 == 3 || f3 == 6 || f3 == 7) return 0;
    if (wr && f3 >= 4) return 0;
    if (sz == 1 && (a % 2) != 0) return 0;
    if (sz == 2 && (a % 4) != 0) return 0;
    return 1;
  endfunction

  function automatic logic [3:0] m_be(input int f3, input int a);
    int nb;
    nb = 1 << (f3 % 4);
    return 4'(((1 << nb) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input int f3,
                                          input logic [31:0] d);
    case (f3 % 4)
      0:       return {24'd0, d[7:0]} * 32'h01010101;
      1:       return {16'd0, d[15:0]} * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input int f3, input int a,
                                         input logic [31:0] w);
    logic [31:0] v, mask;
    int nbits;
    nbits = 8 << (f3 % 4);
    if (nbits >= 32) return w;
    mask = (32'd1 << nbits) - 1;
    v = (w >> (8 * (a % 4))) & mask;
    if (f3 < 4 && v[nbits-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic idle_inputs();
    valid_i = 0; mem_read_i = 0; mem_write_i = 0;
    funct3_i = 0; alu_result_i = 0; store_data_i = 0;
    mem_ack_i = 0; mem_rdata_i = 0;
  endtask

  // One instruction through the unit; dly = ACCESS cycles before ack.
  task automatic run(input bit vld, input bit rd, input bit wr,
                     input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] sd, input logic [31:0] rw,
                     input int dly);
    bit lg, flt;
    lg  = vld && m_legal(rd, wr, int'(f3), int'(a[1:0]));
    flt = vld && !lg && (rd || wr);
    valid_i = vld; mem_read_i = rd; mem_write_i = wr;
    funct3_i = f3; alu_result_i = a; store_data_i = sd;
    mem_ack_i = 0;
    @(negedge clk_i);
    chk("idle_stall", 32'(stall_o), 32'(lg));
    chk("idle_fault", 32'(fault_o), 32'(flt));
    chk("idle_req", 32'(mem_req_o), 32'd0);
    @(posedge clk_i); #1;
    if (lg) begin
      for (int c = 0; c <= dly; c++) begin
        mem_ack_i   = (c == dly);
        mem_rdata_i = (c == dly) ? rw : $urandom;
        @(negedge clk_i);
        chk("acc_req", 32'(mem_req_o), 32'd1);
        chk("acc_stall", 32'(stall_o), 32'd1);
        chk("acc_done", 32'(done_o), 32'd0);
        chk("acc_we", 32'(mem_we_o), 32'(wr));
        chk("acc_addr", mem_addr_o, a & ~32'd3);
        chk("acc_be", 32'(mem_be_o),
            32'(m_be(int'(f3), int'(a[1:0]))));
        if (wr) chk("acc_wdata", mem_wdata_o,
                    m_wdata(int'(f3), sd));
        @(posedge clk_i); #1;
      end
      mem_ack_i = 0;
      if (rd) m_rd = m_load(int'(f3), int'(a[1:0]), rw);
      @(negedge clk_i);
      chk("done_pulse", 32'(done_o), 32'd1);
      chk("done_stall", 32'(stall_o), 32'd0);
      chk("done_req", 32'(mem_req_o), 32'd0);
      chk("done_fault", 32'(fault_o), 32'd0);
      chk("done_data", data_read_o, m_rd);
      @(posedge clk_i); #1;
    end
    idle_inputs();
    mem_ack_i   = 1'($urandom);
    mem_rdata_i = $urandom;
    @(negedge clk_i);
    chk("rest_req", 32'(mem_req_o), 32'd0);
    chk("rest_done", 32'(done_o), 32'd0);
    chk("rest_fault", 32'(fault_o), 32'd0);
    chk("rest_data", data_read_o, m_rd);
    @(posedge clk_i); #1;
    mem_ack_i = 0;
  endtask

  initial begin
    int kind;
    bit rd, wr;
    idle_inputs();
    reset_i = 1;
    repeat (2) @(posedge clk_i);
    #1;
    @(negedge clk_i);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_fault", 32'(fault_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_be", 32'(mem_be_o), 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_data", data_read_o, 32'd0);
    @(posedge clk_i); #1;
    reset_i = 0;

    run(1, 1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 1);
    run(1, 1, 0, 3'b000, 32'h203, 0, 32'h80FF1234, 0);
    run(1, 1, 0, 3'b100, 32'h203, 0, 32'h80FF1234, 2);
    run(1, 1, 0, 3'b101, 32'h202, 0, 32'h80FF1234, 0);
    run(1, 0, 1, 3'b001, 32'h306, 32'h0000ABCD, 0, 1);
    run(1, 1, 0, 3'b010, 32'h102, 0, 0, 0);
    run(1, 1, 1, 3'b010, 32'h100, 0, 0, 0);
    run(1, 0, 1, 3'b100, 32'h100, 0, 0, 0);
    run(1, 1, 0, 3'b111, 32'h100, 0, 0, 0);
    run(1, 0, 1, 3'b000, 32'h101, 32'h123456A5, 0, 0);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      rd = (kind == 0) || (kind >= 2 && kind <= 5);
      wr = (kind == 0) || (kind >= 6);
      run(1, rd, wr, 3'($urandom), $urandom, $urandom,
          $urandom, $urandom_range(0, 2));
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    valid_i = 1; mem_read_i = 1; funct3_i = 3'b010;
    alu_result_i = 32'h40;
    @(posedge clk_i); #1;
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      chk("tmo_req", 32'(mem_req_o), 32'd1);
      chk("tmo_done_early", 32'(done_o), 32'd0);
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    chk("tmo_req_drop", 32'(mem_req_o), 32'd0);
    chk("tmo_done", 32'(done_o), 32'd1);
    chk("tmo_fault", 32'(fault_o), 32'd1);
    chk("tmo_stall", 32'(stall_o), 32'd0);
    chk("tmo_data", data_read_o, m_rd);
    @(posedge clk_i); #1;
`endif

    // reset in the middle of a transaction, then a stray ack
    valid_i = 1; mem_read_i = 1; funct3_i = 3'b010;
    alu_result_i = 32'h100;
    @(posedge clk_i); #1;
    idle_inputs();
    reset_i = 1;
    @(negedge clk_i);
    chk("mid_req_pre", 32'(mem_req_o), 32'd1);
    @(posedge clk_i); #1;
    reset_i = 0;
    mem_ack_i = 1; mem_rdata_i = 32'h5555AAAA;
    m_rd = 32'd0;
    @(negedge clk_i);
    chk("mid_req", 32'(mem_req_o), 32'd0);
    chk("mid_stall", 32'(stall_o), 32'd0);
    chk("mid_done", 32'(done_o), 32'd0);
    chk("mid_addr", mem_addr_o, 32'd0);
    chk("mid_data", data_read_o, m_rd);
    @(posedge clk_i); #1;
    mem_ack_i = 0;
    @(negedge clk_i);
    chk("mid_done2", 32'(done_o), 32'd0);
    chk("mid_data2", data_read_o, m_rd);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
